// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, frame constants and baud divisor helpers for uart_tx_fifo
package uart_pkg;

    localparam int FRAME_BITS = 11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;

    function automatic int unsigned baud_rate(input logic [3:0] sel);
        case (sel)
            4'd0:    return 300;
            4'd1:    return 1200;
            4'd2:    return 2400;
            4'd3:    return 4800;
            4'd4:    return 9600;
            4'd5:    return 19200;
            4'd6:    return 38400;
            4'd7:    return 57600;
            4'd8:    return 115200;
            4'd9:    return 230400;
            4'd10:   return 460800;
            default: return 921600;
        endcase
    endfunction

    // Rounded to nearest; never returns 0 so the baud counter always has a terminal count.
    function automatic logic [31:0] divisor(input int unsigned clk_hz, input logic [3:0] sel);
        longint unsigned baud;
        longint unsigned div;
        baud = longint'(baud_rate(sel));
        div  = (longint'(clk_hz) + baud / 2) / baud;
        if (div == 0) begin
            div = 1;
        end
        return div[31:0];
    endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// rtl/uart_tx_fifo_fifo.sv - show-ahead synchronous byte FIFO feeding the UART serialiser
module tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage is not reset; a flush only needs the pointers and count cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with port decode, overflow flag and level interrupt
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int          DEPTH     = 16,
    parameter int          IRQ_LEVEL = 0,
    parameter logic [15:0] PORT_BASE = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            port_id,
    input  logic                   write_strobe,
    input  logic [15:0]            out_port,
    input  logic                   interrupt_ack,
    input  logic [3:0]             baud_sel,
    input  logic                   eight,
    input  logic                   pen,
    input  logic                   ohel,
    output logic                   tx,
    output logic                   tx_rdy,
    output logic                   tx_busy,
    output logic                   interrupt,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  push_req;
    logic                  clr_req;
    logic                  push_ok;
    logic                  pop;
    logic [7:0]            fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FRAME_BITS-1:0] frame_d;
    logic                  parity;
    logic                  bit_end;
    logic                  last_bit;
    logic                  low_d;
    logic                  unused_hi;

    tx_state_e             state_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic                  busy_q;
    logic [31:0]           div_q;
    logic [31:0]           baud_cnt_q;
    logic [3:0]            bit_cnt_q;
    logic                  ovf_q;
    logic                  low_q;
    logic                  low_prev_q;
    logic                  irq_q;

    logic [31:0]           div_tab [16];

    // Each entry folds to a constant because CLK_HZ and the index are elaboration-time values.
    for (genvar g = 0; g < 16; g++) begin : g_div
        assign div_tab[g] = divisor(CLK_HZ, 4'(g));
    end

    assign push_req  = write_strobe && (port_id == PORT_BASE);
    assign clr_req   = write_strobe && (port_id == PORT_BASE + 16'd1);
    assign push_ok   = push_req && (!fifo_full || pop);
    assign unused_hi = ^out_port[15:8];

    tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop),
        .din   (out_port[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end  = (baud_cnt_q == div_q - 32'd1);
    assign last_bit = (bit_cnt_q == 4'(FRAME_BITS - 1));
    assign pop      = !fifo_empty && ((state_q == IDLE) || (bit_end && last_bit));

    // Frame image, LSB transmitted first; unused tail positions stay 1 as extra stop bits.
    always_comb begin
        frame_d = '1;
        parity  = 1'b0;
        if (eight) begin
            parity       = (^fifo_dout) ^ ohel;
            frame_d[8:1] = fifo_dout;
            if (pen) begin
                frame_d[9] = parity;
            end
        end else begin
            parity       = (^fifo_dout[6:0]) ^ ohel;
            frame_d[7:1] = fifo_dout[6:0];
            if (pen) begin
                frame_d[8] = parity;
            end
        end
        frame_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '1;
            busy_q     <= 1'b0;
            div_q      <= 32'd1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else if (pop) begin
            state_q    <= SHIFT;
            shreg_q    <= frame_d;
            busy_q     <= 1'b1;
            div_q      <= div_tab[baud_sel];
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else if (state_q == SHIFT) begin
            if (!bit_end) begin
                baud_cnt_q <= baud_cnt_q + 32'd1;
            end else if (last_bit) begin
                state_q    <= IDLE;
                shreg_q    <= '1;
                busy_q     <= 1'b0;
                baud_cnt_q <= '0;
            end else begin
                baud_cnt_q <= '0;
                bit_cnt_q  <= bit_cnt_q + 4'd1;
                shreg_q    <= {1'b1, shreg_q[FRAME_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (push_req && !push_ok) begin
            ovf_q <= 1'b1;
        end else if (clr_req) begin
            ovf_q <= 1'b0;
        end
    end

    // low_q resets low so the first sample after reset is seen as a rising edge.
    assign low_d = (fifo_count <= CW'(IRQ_LEVEL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_q      <= 1'b0;
            low_prev_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            low_q      <= low_d;
            low_prev_q <= low_q;
            if (low_q && !low_prev_q) begin
                irq_q <= 1'b1;
            end else if (interrupt_ack) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign tx        = shreg_q[0];
    assign tx_rdy    = !fifo_full;
    assign tx_busy   = busy_q;
    assign interrupt = irq_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a frame scoreboard
module tb_uart_tx_fifo;

    localparam logic [15:0] BASE = 16'h0040;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] port_id = 16'hFFFF;
    logic        write_strobe = 1'b0;
    logic [15:0] out_port = 16'h0000;
    logic        interrupt_ack = 1'b0;
    logic [3:0]  baud_sel = 4'd11;
    logic        eight = 1'b1;
    logic        pen = 1'b0;
    logic        ohel = 1'b0;
    logic        tx;
    logic        tx_rdy;
    logic        tx_busy;
    logic        interrupt;
    logic        overflow;
    logic [4:0]  fifo_count;

    uart_tx_fifo #(
        .CLK_HZ    (1_000_000),
        .DEPTH     (16),
        .IRQ_LEVEL (0),
        .PORT_BASE (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .out_port      (out_port),
        .interrupt_ack (interrupt_ack),
        .baud_sel      (baud_sel),
        .eight         (eight),
        .pen           (pen),
        .ohel          (ohel),
        .tx            (tx),
        .tx_rdy        (tx_rdy),
        .tx_busy       (tx_busy),
        .interrupt     (interrupt),
        .overflow      (overflow),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [10:0] bits;
        int          div;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic        eight;
        logic        pen;
        logic        ohel;
        logic [3:0]  sel;
        logic [10:0] bits;
        int          div;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[8];

    logic m_active = 1'b0;
    exp_t m_cur;
    int   m_bit = 0;
    int   m_cyc = 0;
    int   m_txerr = 0;
    int   m_busyerr = 0;
    int   m_end = -100;
    int   n_frames = 0;
    int   n_contig = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Frame monitor: every cycle of every bit is compared against the expected level.
    always @(negedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            exp_q.delete();
        end else begin
            if (!m_active && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, want none", cyc);
                end else begin
                    m_cur     = exp_q.pop_front();
                    m_active  = 1'b1;
                    m_bit     = 0;
                    m_cyc     = 0;
                    m_txerr   = 0;
                    m_busyerr = 0;
                    if (cyc == m_end) n_contig++;
                end
            end
            if (m_active) begin
                if (tx !== m_cur.bits[m_bit]) m_txerr++;
                if (tx_busy !== 1'b1) m_busyerr++;
                m_cyc++;
                if (m_cyc == m_cur.div) begin
                    check($sformatf("frame%0d_bit%0d_bad_cycles", n_frames, m_bit), m_txerr, 0);
                    m_txerr = 0;
                    m_cyc   = 0;
                    m_bit++;
                    if (m_bit == 11) begin
                        check($sformatf("frame%0d_busy_low_cycles", n_frames), m_busyerr, 0);
                        m_active = 1'b0;
                        n_frames++;
                        m_end = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic drive_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        port_id      = addr;
        out_port     = {~data, data};
        write_strobe = 1'b1;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        write_strobe = 1'b0;
        port_id      = BASE + 16'h0010;
    endtask

    task automatic push_exp(input logic [7:0] data, input logic [10:0] bits, input int div);
        exp_t e;
        e.bits = bits;
        e.div  = div;
        drive_write(BASE, data);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_active) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained_in_time"}, 32'(n < max_cyc), 1);
        @(negedge clk);
        check({name, "_idle_tx"}, tx, 1);
        check({name, "_idle_busy"}, tx_busy, 0);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
    endtask

    task automatic reset_dut();
        reset         = 1'b1;
        write_strobe  = 1'b0;
        interrupt_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c0;
        int f0;
        int n;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 4'd8,  11'b11101001010, 9};
        tbl[1] = '{8'h41, 1'b0, 1'b1, 1'b1, 4'd11, 11'b11110000010, 1};
        tbl[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 4'd10, 11'b10001111000, 2};
        tbl[3] = '{8'h80, 1'b0, 1'b0, 1'b0, 4'd9,  11'b11100000000, 4};
        tbl[4] = '{8'hC3, 1'b1, 1'b1, 1'b1, 4'd11, 11'b11110000110, 1};
        tbl[5] = '{8'h2B, 1'b0, 1'b1, 1'b0, 4'd12, 11'b11001010110, 1};
        tbl[6] = '{8'h57, 1'b1, 1'b0, 1'b0, 4'd7,  11'b11010101110, 17};
        tbl[7] = '{8'h01, 1'b1, 1'b1, 1'b0, 4'd15, 11'b11000000010, 1};

        // Reset values, then interrupt rising two cycles after release.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_rdy", tx_rdy, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_interrupt", interrupt, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fifo_count", fifo_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("irq_cycle1", interrupt, 0);
        @(negedge clk);
        check("irq_cycle2", interrupt, 1);
        ack_pulse();
        check("irq_after_ack", interrupt, 0);
        repeat (20) @(negedge clk);
        check("irq_stays_clear", interrupt, 0);
        check("idle_tx_no_writes", tx, 1);

        // Set wins over an acknowledge held through the post-reset edge.
        reset_dut();
        interrupt_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("irq_set_beats_ack_reset", interrupt, 1);
        interrupt_ack = 1'b0;
        ack_pulse();

        // First frame: push latency and start bit at strobe+2.
        eight    = tbl[0].eight;
        pen      = tbl[0].pen;
        ohel     = tbl[0].ohel;
        baud_sel = tbl[0].sel;
        push_exp(tbl[0].data, tbl[0].bits, tbl[0].div);
        bus_idle();
        check("lat_count_n1", fifo_count, 1);
        check("lat_tx_n1", tx, 1);
        @(negedge clk);
        check("lat_tx_n2_start", tx, 0);
        check("lat_busy_n2", tx_busy, 1);
        check("lat_count_n2", fifo_count, 0);
        wait_drain("vec0", 200);

        for (int i = 1; i < 8; i++) begin
            eight    = tbl[i].eight;
            pen      = tbl[i].pen;
            ohel     = tbl[i].ohel;
            baud_sel = tbl[i].sel;
            push_exp(tbl[i].data, tbl[i].bits, tbl[i].div);
            bus_idle();
            wait_drain($sformatf("vec%0d", i), 11 * tbl[i].div + 20);
        end

        // Settings changed mid-frame only apply to later frames.
        eight    = 1'b0;
        pen      = 1'b1;
        ohel     = 1'b1;
        baud_sel = 4'd8;
        push_exp(8'h41, 11'b11110000010, 9);
        bus_idle();
        repeat (20) @(negedge clk);
        ohel     = 1'b0;
        baud_sel = 4'd0;
        wait_drain("ohel_mid_frame", 200);

        // Overflow: one frame running, 16 bytes fill the FIFO, the 17th is dropped.
        eight    = 1'b1;
        pen      = 1'b0;
        baud_sel = 4'd8;
        push_exp(8'h10, {2'b11, 8'h10, 1'b0}, 9);
        bus_idle();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) push_exp(8'(8'h20 + i), {2'b11, 8'(8'h20 + i), 1'b0}, 9);
            else drive_write(BASE, 8'hEE);
        end
        bus_idle();
        check("ovf_count_full", fifo_count, 16);
        check("ovf_tx_rdy_low", tx_rdy, 0);
        check("ovf_flag_set", overflow, 1);
        drive_write(BASE + 16'd2, 8'h99);
        bus_idle();
        check("ovf_other_port_no_push", fifo_count, 16);
        check("ovf_other_port_no_clear", overflow, 1);
        drive_write(BASE + 16'd1, 8'h00);
        bus_idle();
        check("ovf_cleared", overflow, 0);
        c0 = n_contig;
        wait_drain("ovf_drain", 17 * 99 + 60);
        check("ovf_contiguous_frames", n_contig - c0, 16);
        check("ovf_tx_rdy_after", tx_rdy, 1);

        // Three back-to-back frames; interrupt two cycles after the FIFO empties.
        baud_sel = 4'd11;
        pen      = 1'b1;
        ohel     = 1'b0;
        ack_pulse();
        check("irq3_clear_before", interrupt, 0);
        c0 = n_contig;
        push_exp(8'h11, {1'b1, 1'b0, 8'h11, 1'b0}, 1);
        push_exp(8'h22, {1'b1, 1'b0, 8'h22, 1'b0}, 1);
        push_exp(8'h33, {1'b1, 1'b0, 8'h33, 1'b0}, 1);
        bus_idle();
        n = 0;
        while (fifo_count != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("irq3_fifo_emptied", 32'(n < 100), 1);
        check("irq3_m", interrupt, 0);
        @(negedge clk);
        check("irq3_m1", interrupt, 0);
        interrupt_ack = 1'b1;
        @(negedge clk);
        interrupt_ack = 1'b0;
        check("irq3_m2_set_beats_ack", interrupt, 1);
        @(negedge clk);
        check("irq3_holds", interrupt, 1);
        ack_pulse();
        check("irq3_acked", interrupt, 0);
        wait_drain("three_frames", 100);
        check("three_frames_contiguous", n_contig - c0, 2);

        // Reset in the middle of bit 5 with frames queued.
        baud_sel = 4'd8;
        pen      = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(8'(8'h5A + i), {2'b11, 8'(8'h5A + i), 1'b0}, 9);
        bus_idle();
        repeat (47) @(negedge clk);
        check("mid_reset_tx_low_before", tx_busy, 1);
        f0 = n_frames;
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_tx", tx, 1);
        check("mid_reset_count", fifo_count, 0);
        check("mid_reset_busy", tx_busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("mid_reset_no_frames", n_frames - f0, 0);
        check("mid_reset_idle_tx", tx, 1);
        check("mid_reset_count_after", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
